// File: rtl/out_port.sv
// out_port: memory-mapped serial transmit port on the CPU1 external bus.
// CPU writes to DATA_ADDR are queued in a small byte FIFO. Each byte is sent
// as one asynchronous frame: a start bit, 8 data bits LSB first, and a stop bit.
// When the last queued frame finishes, o_set pulses for one cycle.
// A status byte {ovf, full, empty, busy} can be read at STAT_ADDR.
// Optional feature: define OUT_PORT_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module out_port #(
  parameter logic [15:0] DATA_ADDR = 16'h00F0,
  parameter logic [15:0] STAT_ADDR = 16'h00F1,
  parameter int          DIV       = 16,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] F_adr,
  inout  wire  [15:0] F_data,
  input  logic        M_RW,
  output logic        tx,
  output logic        o_set,
  output logic        busy
);

  localparam int CW = $clog2(DIV);
  localparam int PW = $clog2(DEPTH);

`ifdef OUT_PORT_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  // Bus decode and FIFO state
  logic          w_wr_hit, w_rd_hit, w_push, w_push_ok, w_rd_first;
  logic          w_empty, w_full, w_div_end, w_pop;
  logic [7:0]    w_head;
  logic [15:0]   w_status;
  logic          w_unused_hi;
  logic          r_wr_prev, r_rd_prev, r_ovf;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_cnt;

  // Serializer state
  state_t        r_state;
  logic [CW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx, r_set, r_busy;
`ifdef OUT_PORT_PARITY_EN
  logic          r_par;
`endif

  assign w_wr_hit    = !M_RW && (F_adr == DATA_ADDR);
  assign w_rd_hit    =  M_RW && (F_adr == STAT_ADDR);
  // Only the first cycle of a contiguous hit run counts, so a CPU that holds
  // the bus for several cycles still enqueues or acknowledges exactly once.
  assign w_push      = w_wr_hit && !r_wr_prev;
  assign w_rd_first  = w_rd_hit && !r_rd_prev;
  assign w_empty     = (r_cnt == '0);
  assign w_full      = (r_cnt == (PW+1)'(DEPTH));
  assign w_div_end   = (r_div == CW'(DIV - 1));
  assign w_head      = r_mem[r_rptr];
  // The serializer takes a byte either from IDLE or at the end of a stop bit,
  // which is how back-to-back frames avoid an idle gap.
  assign w_pop       = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_STOP) && w_div_end));
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_status    = {8'h00, 4'h0, r_ovf, w_full, w_empty, r_busy};
  assign F_data      = w_rd_hit ? w_status : 16'hzzzz;
  assign w_unused_hi = &{1'b0, F_data[15:8]};

  assign tx    = r_tx;
  assign o_set = r_set;
  assign busy  = r_busy;

  // FIFO storage: data only, no reset needed since pointers define validity
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= F_data[7:0];
  end

  // FIFO pointers, occupancy count, run-edge flags and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_wr_prev <= 1'b0;
      r_rd_prev <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_prev <= w_wr_hit;
      r_rd_prev <= w_rd_hit;
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      // A drop in the same cycle as the clearing read must stay visible.
      if (w_push && !w_push_ok) r_ovf <= 1'b1;
      else if (w_rd_first)      r_ovf <= 1'b0;
    end
  end

  // Serializer FSM with registered tx/busy/o_set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_set   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_set <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
`ifdef OUT_PORT_PARITY_EN
            r_par   <= ^w_head;
`endif
            r_state <= S_START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
          end
        end
        S_START: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DATA: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_bit == 3'd7) begin
`ifdef OUT_PORT_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_par;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`ifdef OUT_PORT_PARITY_EN
        S_PARITY: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_div_end) begin
            r_div <= '0;
            if (w_pop) begin
              r_shift <= w_head;
`ifdef OUT_PORT_PARITY_EN
              r_par   <= ^w_head;
`endif
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_set   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port.sv
// tb_out_port: randomized bench for out_port. The reference model describes the
// expected {tx, busy, o_set} waveform directly from the frame format: frames of
// NB bits, DIV clocks each, sent back to back, followed by a one-cycle o_set.
module tb_out_port;

  localparam logic [15:0] DATA_ADDR = 16'h00F0;
  localparam logic [15:0] STAT_ADDR = 16'h00F1;
  localparam int DIV   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_PORT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;
  localparam int S0 = 2;  // capture index of the first start-bit cycle

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] F_adr = 16'h0000;
  logic        M_RW = 1'b1;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = 16'h0000;
  wire  [15:0] F_data;
  logic        tx, o_set, busy;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] exp_bytes[$];
  logic [2:0] cap_q[$];

  assign F_data = tb_drv ? tb_wdata : 16'hzzzz;

  out_port #(.DATA_ADDR(DATA_ADDR), .STAT_ADDR(STAT_ADDR), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .F_adr(F_adr), .F_data(F_data), .M_RW(M_RW),
    .tx(tx), .o_set(o_set), .busy(busy)
  );

  always #5 clk = ~clk;

  // Bit k of the serial frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef OUT_PORT_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Expected {tx, busy, o_set} at capture index i when exp_bytes start at index s.
  function automatic logic [2:0] model_out(input int i, input int s);
    int nf = exp_bytes.size();
    int e  = s + nf * FL;
    int f, k;
    if (nf == 0 || i < s || i > e) return 3'b100;
    if (i == e) return 3'b101;
    f = (i - s) / FL;
    k = ((i - s) % FL) / DIV;
    return {frame_bit(exp_bytes[f], k), 2'b10};
  endfunction

  task automatic bus_idle();
    M_RW = 1'b1; F_adr = 16'h0000; tb_drv = 1'b0;
  endtask

  // Write run of h cycles; data changes after the first cycle to prove only
  // the first cycle is captured. Then g extra idle cycles.
  task automatic bus_write(input logic [7:0] d, input int h, input int g);
    @(posedge clk); #1;
    M_RW = 1'b0; F_adr = DATA_ADDR; tb_drv = 1'b1; tb_wdata = {8'($urandom), d};
    repeat (h) begin @(posedge clk); #1; tb_wdata[7:0] = ~d; end
    bus_idle();
    repeat (g) begin @(posedge clk); #1; end
  endtask

  task automatic bus_read(output logic [15:0] v);
    @(posedge clk); #1;
    M_RW = 1'b1; F_adr = STAT_ADDR; tb_drv = 1'b0;
    #1 v = F_data;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic capture(input int n);
    cap_q.delete();
    repeat (n) begin @(posedge clk); #1; cap_q.push_back({tx, busy, o_set}); end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1; bus_idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_total++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (o_set !== 1'b0) $display("FAIL reset_oset: got %b want 0", o_set); else n_pass++;
    bus_read(v);
    n_total++; if (v !== 16'h0002) $display("FAIL reset_status: got %h want 0002", v); else n_pass++;
  endtask

  task automatic test_single(input logic [7:0] b, input string name);
    int bad = -1;
    exp_bytes.delete(); exp_bytes.push_back(b);
    fork
      bus_write(b, 3, 0);
      capture(S0 + FL + 8);
    join
    foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== model_out(i, S0)) bad = i;
    n_total++;
    if (bad >= 0) $display("FAIL %s: cycle %0d {tx,busy,o_set} got %b want %b",
                           name, bad, cap_q[bad], model_out(bad, S0));
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    exp_bytes.delete();
    for (int k = 0; k < 5; k++) exp_bytes.push_back(8'($urandom));
    fork
      for (int k = 0; k < 5; k++) bus_write(exp_bytes[k], 1, 0);
      capture(S0 + 5 * FL + 6);
    join
    foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== model_out(i, S0)) bad = i;
    n_total++;
    if (bad >= 0) $display("FAIL back_to_back: cycle %0d {tx,busy,o_set} got %b want %b",
                           bad, cap_q[bad], model_out(bad, S0));
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int bad = -1;
      int n = $urandom_range(1, 4);
      int h = $urandom_range(1, 3);
      int g = $urandom_range(0, 2);
      exp_bytes.delete();
      for (int k = 0; k < n; k++) exp_bytes.push_back(8'($urandom));
      fork
        for (int k = 0; k < n; k++) bus_write(exp_bytes[k], h, g);
        capture(S0 + n * FL + 6);
      join
      foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== model_out(i, S0)) bad = i;
      n_total++;
      if (bad >= 0) $display("FAIL random_%0d: cycle %0d {tx,busy,o_set} got %b want %b",
                             it, bad, cap_q[bad], model_out(bad, S0));
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  b[6];
    logic [15:0] v1, v2;
    int bad = -1;
    exp_bytes.delete();
    for (int k = 0; k < 6; k++) b[k] = 8'($urandom);
    for (int k = 0; k < 5; k++) exp_bytes.push_back(b[k]);
    fork
      begin
        for (int k = 0; k < 6; k++) bus_write(b[k], 1, 0);
        bus_read(v1);
        bus_read(v2);
      end
      capture(S0 + 5 * FL + 6);
    join
    n_total++; if (v1 !== 16'h000D) $display("FAIL ovf_status1: got %h want 000d", v1); else n_pass++;
    n_total++; if (v2 !== 16'h0005) $display("FAIL ovf_status2: got %h want 0005", v2); else n_pass++;
    foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== model_out(i, S0)) bad = i;
    n_total++;
    if (bad >= 0) $display("FAIL ovf_frames: cycle %0d {tx,busy,o_set} got %b want %b",
                           bad, cap_q[bad], model_out(bad, S0));
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] v;
    int bad = -1;
    for (int k = 0; k < 3; k++) bus_write(8'($urandom), 1, 0);
    repeat (DIV + 2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_total++; if (tx !== 1'b1) $display("FAIL mid_tx: got %b want 1", tx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (o_set !== 1'b0) $display("FAIL mid_oset: got %b want 0", o_set); else n_pass++;
    bus_read(v);
    n_total++; if (v !== 16'h0002) $display("FAIL mid_status: got %h want 0002", v); else n_pass++;
    exp_bytes.delete();
    capture(FL + 20);
    foreach (cap_q[i]) if (bad < 0 && cap_q[i] !== model_out(i, S0)) bad = i;
    n_total++;
    if (bad >= 0) $display("FAIL mid_quiet: cycle %0d {tx,busy,o_set} got %b want %b",
                           bad, cap_q[bad], model_out(bad, S0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, "single_a5");
    test_single(8'h07, "parity_07");
    test_back_to_back();
    test_random();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
